// File: rtl/cfg_apply_ctrl.sv
// Live configuration owner: validates requested records, pushes accepted ones to the
// datapath over a valid/ready apply channel, and reports one result code per request.
module cfg_apply_ctrl #(
  parameter logic [7:0]  MIN_VERSION     = 8'h01,
  parameter logic [31:0] MAX_WIDTH_LIMIT = 32'd1024,
  parameter int unsigned TIMEOUT_CYCLES  = 16,
  parameter int          CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [55:0]      req_cfg_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [1:0]       resp_code_o,
  output logic             apply_valid_o,
  input  logic             apply_ready_i,
  output logic [55:0]      apply_cfg_o,
  input  logic             restore_default_i,
  output logic [55:0]      active_cfg_o,
  output logic [CNT_W-1:0] apply_count_o,
  output logic             busy_o
);

  localparam logic [55:0] DEFAULT_CFG = {8'h01, 16'hFFFF, 32'd32};
  localparam logic [1:0]  RC_SUCCESS  = 2'd0;
  localparam logic [1:0]  RC_FAILURE  = 2'd1;
  localparam logic [1:0]  RC_ERROR    = 2'd2;
  localparam logic        TO_EN       = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST     = 32'(TIMEOUT_CYCLES) - 32'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_APPLY = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [55:0]      pend_q, pend_d;
  logic [55:0]      active_q, active_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      timer_q, timer_d;
  logic [1:0]       code_q, code_d;
  logic             cfg_pass;
  logic             timeout_hit;

  function automatic logic cfg_ok(input logic [55:0] c);
    logic [7:0]  ver;
    logic [31:0] mw;
    ver = c[55:48];
    mw  = c[31:0];
    return (mw != 32'd0) && (mw <= MAX_WIDTH_LIMIT) && (ver >= MIN_VERSION);
  endfunction

  assign cfg_pass = cfg_ok(pend_q);
  // Fires on the last permitted waiting cycle so apply_valid is high for exactly TIMEOUT_CYCLES.
  assign timeout_hit = TO_EN && (timer_q == TO_LAST) && !apply_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!restore_default_i && req_valid_i) state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = cfg_pass ? S_APPLY : S_RESP;
      end
      S_APPLY: begin
        if (apply_ready_i || timeout_hit) state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o   = (state_q == S_IDLE) && !restore_default_i && !rst;
    resp_valid_o  = (state_q == S_RESP);
    apply_valid_o = (state_q == S_APPLY);
    apply_cfg_o   = (state_q == S_APPLY) ? pend_q : 56'd0;
    busy_o        = (state_q != S_IDLE);
    resp_code_o   = code_q;
    active_cfg_o  = active_q;
    apply_count_o = count_q;
  end

  always_comb begin
    pend_d   = pend_q;
    active_d = active_q;
    count_d  = count_q;
    timer_d  = 32'd0;
    code_d   = code_q;
    unique case (state_q)
      S_IDLE: begin
        if (restore_default_i) begin
          active_d = DEFAULT_CFG;
        end else if (req_valid_i) begin
          pend_d = req_cfg_i;
        end
      end
      S_CHECK: begin
        if (!cfg_pass) code_d = RC_FAILURE;
      end
      S_APPLY: begin
        if (apply_ready_i) begin
          active_d = pend_q;
          count_d  = count_q + 1'b1;
          code_d   = RC_SUCCESS;
        end else if (timeout_hit) begin
          code_d = RC_ERROR;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= DEFAULT_CFG;
      count_q  <= '0;
      timer_q  <= 32'd0;
      code_q   <= RC_SUCCESS;
    end else begin
      active_q <= active_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      code_q   <= code_d;
    end
  end

  // Pending record is only observed behind apply_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end

endmodule

// File: tb/tb_cfg_apply_ctrl.sv
// Scoreboard bench for cfg_apply_ctrl: expected responses are queued when a request is
// driven and compared when the response handshake is observed.
module tb_cfg_apply_ctrl;

  localparam logic [55:0] DEF_CFG = {8'h01, 16'hFFFF, 32'd32};

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [55:0] req_cfg;
  logic        resp_valid, resp_ready;
  logic [1:0]  resp_code;
  logic        apply_valid, apply_ready;
  logic [55:0] apply_cfg;
  logic        restore_default;
  logic [55:0] active_cfg;
  logic [15:0] apply_count;
  logic        busy;

  typedef struct packed {
    logic [1:0]  code;
    logic [55:0] act;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          av_cnt   = 0;
  logic [55:0] exp_active = DEF_CFG;
  logic [15:0] exp_count  = '0;
  logic [55:0] cur_pend   = '0;

  cfg_apply_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_cfg_i         (req_cfg),
    .resp_valid_o      (resp_valid),
    .resp_ready_i      (resp_ready),
    .resp_code_o       (resp_code),
    .apply_valid_o     (apply_valid),
    .apply_ready_i     (apply_ready),
    .apply_cfg_o       (apply_cfg),
    .restore_default_i (restore_default),
    .active_cfg_o      (active_cfg),
    .apply_count_o     (apply_count),
    .busy_o            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (apply_valid) begin
        av_cnt++;
        chk("apply_cfg_live", apply_cfg, cur_pend);
      end else begin
        chk("apply_cfg_zero", apply_cfg, 56'd0);
      end
      if (resp_valid && resp_ready) begin
        if (sb_q.size() == 0) begin
          chk("resp_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("resp_code", resp_code, e.code);
          chk("resp_active", active_cfg, e.act);
          chk("resp_count", apply_count, e.cnt);
        end
      end
    end
  end

  task automatic do_req(input logic [55:0] cfg, input logic [1:0] code, input bit push);
    int n;
    exp_t e;
    req_cfg   = cfg;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("req_accept_wait", 1, 0);
    cur_pend = cfg;
    if (push) begin
      if (code == 2'd0) begin
        exp_active = cfg;
        exp_count  = exp_count + 16'd1;
      end
      e.code = code;
      e.act  = exp_active;
      e.cnt  = exp_count;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 200) chk("resp_wait", sb_q.size(), 0);
  endtask

  task automatic wait_apply();
    int n;
    n = 0;
    while (!apply_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("apply_wait", 1, 0);
  endtask

  initial begin
    logic [55:0] cfg2;
    cfg2 = {8'h02, 16'h00F0, 32'd64};
    rst = 1'b1; req_valid = 1'b0; req_cfg = '0; resp_ready = 1'b1;
    apply_ready = 1'b1; restore_default = 1'b0;

    // Reset and idle values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_apply_valid", apply_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_active", active_cfg, DEF_CFG);
    chk("idle_count", apply_count, 0);
    chk("idle_req_ready", req_ready, 1);
    chk("idle_resp_valid", resp_valid, 0);
    chk("idle_resp_code", resp_code, 0);
    chk("idle_busy", busy, 0);

    // Successful apply with latency checks
    av_cnt = 0;
    do_req(cfg2, 2'd0, 1'b1);
    chk("chk_state_apply_valid", apply_valid, 0);
    chk("chk_state_busy", busy, 1);
    @(posedge clk); #1;
    chk("apply_valid_rise", apply_valid, 1);
    chk("active_before_apply", active_cfg, DEF_CFG);
    @(posedge clk); #1;
    chk("apply_valid_fall", apply_valid, 0);
    chk("active_after_apply", active_cfg, cfg2);
    chk("resp_valid_rise", resp_valid, 1);
    wait_resp();
    chk("ok_back_idle", busy, 0);
    chk("ok_apply_cycles", av_cnt, 1);

    // Validation failures
    av_cnt = 0;
    do_req({8'h05, 16'h1234, 32'd0},    2'd1, 1'b1); wait_resp();
    do_req({8'h05, 16'h1234, 32'd1025}, 2'd1, 1'b1); wait_resp();
    do_req({8'h00, 16'h1234, 32'd8},    2'd1, 1'b1); wait_resp();
    do_req({8'hFF, 16'h0001, 32'd1024}, 2'd0, 1'b1); wait_resp();
    chk("fail_apply_cycles", av_cnt, 1);

    // Apply timeout, then ready on the final waiting cycle
    apply_ready = 1'b0;
    av_cnt = 0;
    do_req({8'h03, 16'h0F0F, 32'd100}, 2'd2, 1'b1); wait_resp();
    chk("to_apply_cycles", av_cnt, 16);
    av_cnt = 0;
    do_req({8'h04, 16'hAAAA, 32'd200}, 2'd0, 1'b1);
    wait_apply();
    repeat (15) @(posedge clk);
    #1;
    apply_ready = 1'b1;
    wait_resp();
    chk("late_ready_cycles", av_cnt, 16);

    // Response back-pressure
    resp_ready = 1'b0;
    do_req({8'h07, 16'h0000, 32'd2000}, 2'd1, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_resp_code", resp_code, 1);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    wait_resp();
    chk("bp_idle", busy, 0);
    chk("bp_resp_drop", resp_valid, 0);

    // Restore default blocks a simultaneous request
    restore_default = 1'b1;
    req_valid = 1'b1;
    req_cfg = cfg2;
    #1;
    chk("restore_req_ready", req_ready, 0);
    @(posedge clk); #1;
    restore_default = 1'b0;
    req_valid = 1'b0;
    exp_active = DEF_CFG;
    chk("restore_active", active_cfg, DEF_CFG);
    chk("restore_busy", busy, 0);
    chk("restore_count", apply_count, exp_count);
    @(posedge clk); #1;
    chk("restore_no_resp", resp_valid, 0);

    // Reset during APPLY
    apply_ready = 1'b0;
    do_req(cfg2, 2'd0, 1'b0);
    wait_apply();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rrst_apply_valid", apply_valid, 0);
    chk("rrst_apply_cfg", apply_cfg, 0);
    chk("rrst_active", active_cfg, DEF_CFG);
    chk("rrst_count", apply_count, 0);
    chk("rrst_resp_valid", resp_valid, 0);
    chk("rrst_busy", busy, 0);
    chk("rrst_req_ready", req_ready, 0);
    rst = 1'b0;
    exp_active = DEF_CFG;
    exp_count = '0;
    @(posedge clk); #1;
    chk("post_rst_req_ready", req_ready, 1);

    apply_ready = 1'b1;
    do_req({8'h09, 16'h5555, 32'd1}, 2'd0, 1'b1);
    wait_resp();
    chk("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
